// File: rtl/fetch_decode_queue.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue
//
// Elastic instruction queue between the fetch and decode stages of the
// pipelined LEGv8 core. Each fetched {PC, instruction} pair is stored and
// presented to decode in strict FIFO order. Fetch is back-pressured when the
// queue is full. A taken branch (flush) discards every queued entry.
//
// Optional feature (compile-time macro FETCH_DECODE_QUEUE_BYPASS_EN):
//   When the queue is empty and fetch presents a pair, that pair is shown to
//   decode in the same cycle. If decode takes it, it is never written.
//   If the macro is not defined, there is no combinational path from in_* to
//   out_*, and an entry needs at least one cycle to reach the outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   fetch presents a valid pair
//   in_ready   queue can accept a pair this cycle (count != DEPTH)
//   in_pc      PC of the fetched instruction
//   in_instr   fetched instruction word
//   flush      taken branch; discard all entries (synchronous, highest prio)
//   out_valid  head entry valid for decode
//   out_ready  decode consumes the head this cycle
//   out_pc     PC of the head entry (0 when out_valid=0)
//   out_instr  instruction of the head entry (0 when out_valid=0)
//   count      current occupancy
// ----------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage has no reset; its contents only matter under a valid count.
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];

    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign in_ready = ~w_full;
    assign count    = r_count;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed pair that decode accepts in the same cycle is never stored.
    assign w_push = in_valid & in_ready & ~(w_bypass & out_ready);
    // Storage pop only: out_ready is ignored when nothing is stored.
    assign w_pop  = ~w_empty & out_ready;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_pc    = r_mem_pc[r_rd_ptr];
            out_instr = r_mem_instr[r_rd_ptr];
        end
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
        else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Directed bench for fetch_decode_queue (DEPTH=4). Inputs are driven just
// after the falling edge and outputs are sampled 1 ns later, i.e. before the
// rising edge that acts on those inputs. Expected values for cycles where the
// queue is empty and fetch is valid depend on FETCH_DECODE_QUEUE_BYPASS_EN.
// ----------------------------------------------------------------------------
module tb_fetch_decode_queue;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDR_W-1:0]      in_pc;
    logic [INSTR_W-1:0]     in_instr;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_W-1:0]      out_pc;
    logic [INSTR_W-1:0]     out_instr;
    logic [2:0]             count;

    fetch_decode_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [63:0] epc;
        logic [31:0] eins;
        logic [2:0]  cnt;
        logic        ir;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                       input logic fl, input logic ordy, input logic ov,
                       input logic [63:0] epc, input logic [31:0] eins,
                       input logic [2:0] cnt, input logic ir);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ins = ins; v.fl = fl; v.ordy = ordy;
        v.ov = ov; v.epc = epc; v.eins = eins; v.cnt = cnt; v.ir = ir;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [63:0] epc,
                           input logic [31:0] eins, input logic [2:0] cnt, input logic ir);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".out_pc"},    out_pc,         epc);
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(eins));
        chk({tag, ".count"},     64'(count),     64'(cnt));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(ir));
    endtask

    localparam logic [63:0] BIGPC = 64'h0123456789ABCDEF;

    initial begin
        // ---------------- vector table ----------------
        // Fill four entries with decode stalled.
        add(1, 64'h0, 32'h8B1F03E0, 0, 0, BYP, 64'h0, BYP ? 32'h8B1F03E0 : 32'h0, 3'd0, 1);
        add(1, 64'h4, 32'h8B1F03E1, 0, 0, 1, 64'h0, 32'h8B1F03E0, 3'd1, 1);
        add(1, 64'h8, 32'h8B1F03E2, 0, 0, 1, 64'h0, 32'h8B1F03E0, 3'd2, 1);
        add(1, 64'hC, 32'h8B1F03E3, 0, 0, 1, 64'h0, 32'h8B1F03E0, 3'd3, 1);
        // Full: fifth push is ignored.
        add(1, 64'h10, 32'hDEADBEEF, 0, 0, 1, 64'h0, 32'h8B1F03E0, 3'd4, 0);
        // Drain in order.
        add(0, 64'h0, 32'h0, 0, 1, 1, 64'h0, 32'h8B1F03E0, 3'd4, 0);
        add(0, 64'h0, 32'h0, 0, 1, 1, 64'h4, 32'h8B1F03E1, 3'd3, 1);
        add(0, 64'h0, 32'h0, 0, 1, 1, 64'h8, 32'h8B1F03E2, 3'd2, 1);
        add(0, 64'h0, 32'h0, 0, 1, 1, 64'hC, 32'h8B1F03E3, 3'd1, 1);
        // Empty: out_ready ignored, no underflow.
        add(0, 64'h0, 32'h0, 0, 1, 0, 64'h0, 32'h0, 3'd0, 1);
        add(0, 64'h0, 32'h0, 0, 0, 0, 64'h0, 32'h0, 3'd0, 1);
        // Three entries, then flush with a simultaneous push and pop.
        add(1, 64'h100, 32'hA0, 0, 0, BYP, BYP ? 64'h100 : 64'h0, BYP ? 32'hA0 : 32'h0, 3'd0, 1);
        add(1, 64'h104, 32'hA1, 0, 0, 1, 64'h100, 32'hA0, 3'd1, 1);
        add(1, 64'h108, 32'hA2, 0, 0, 1, 64'h100, 32'hA0, 3'd2, 1);
        add(1, BIGPC,   32'hF1, 1, 1, 1, 64'h100, 32'hA0, 3'd3, 1);
        add(1, BIGPC,   32'hF1, 0, 0, BYP, BYP ? BIGPC : 64'h0, BYP ? 32'hF1 : 32'h0, 3'd0, 1);
        add(0, 64'h0,   32'h0,  0, 1, 1, BIGPC, 32'hF1, 3'd1, 1);
        add(0, 64'h0,   32'h0,  0, 0, 0, 64'h0, 32'h0, 3'd0, 1);
        // Full with push+pop: push ignored, slot freed for next cycle.
        add(1, 64'h200, 32'hB0, 0, 0, BYP, BYP ? 64'h200 : 64'h0, BYP ? 32'hB0 : 32'h0, 3'd0, 1);
        add(1, 64'h204, 32'hB1, 0, 0, 1, 64'h200, 32'hB0, 3'd1, 1);
        add(1, 64'h208, 32'hB2, 0, 0, 1, 64'h200, 32'hB0, 3'd2, 1);
        add(1, 64'h20C, 32'hB3, 0, 0, 1, 64'h200, 32'hB0, 3'd3, 1);
        add(1, 64'h210, 32'hB4, 0, 1, 1, 64'h200, 32'hB0, 3'd4, 0);
        add(0, 64'h0,   32'h0,  0, 0, 1, 64'h204, 32'hB1, 3'd3, 1);
        add(0, 64'h0,   32'h0,  0, 1, 1, 64'h204, 32'hB1, 3'd3, 1);
        add(0, 64'h0,   32'h0,  0, 0, 1, 64'h208, 32'hB2, 3'd2, 1);

        // ---------------- reset ----------------
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_all("reset_held", 0, 64'h0, 32'h0, 3'd0, 1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_all("reset_release", 0, 64'h0, 32'h0, 3'd0, 1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_instr  = vecs[i].ins;
            flush     = vecs[i].fl;
            out_ready = vecs[i].ordy;
            #1 chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].epc,
                       vecs[i].eins, vecs[i].cnt, vecs[i].ir);
        end

        // ---------------- asynchronous reset with count=2 ----------------
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1 chk_all("pre_async", 1, 64'h208, 32'hB2, 3'd2, 1);
        #1 reset = 1'b0;
        #1 chk_all("async_reset", 0, 64'h0, 32'h0, 3'd0, 1);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_all("after_async", 0, 64'h0, 32'h0, 3'd0, 1);

        // ---------------- streaming with out_ready=1 ----------------
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_pc     = 64'(4 * i);
            in_instr  = 32'h8B1F0400 + i;
            out_ready = 1'b1;
            #1;
            if (BYP)
                chk_all($sformatf("stream%0d", i), 1, 64'(4 * i), 32'h8B1F0400 + i, 3'd0, 1);
            else if (i == 0)
                chk_all("stream0", 0, 64'h0, 32'h0, 3'd0, 1);
            else
                chk_all($sformatf("stream%0d", i), 1, 64'(4 * (i - 1)),
                        32'h8B1F0400 + (i - 1), 3'd1, 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_pc = '0; in_instr = '0;
        #1;
        if (BYP) chk_all("stream_tail", 0, 64'h0, 32'h0, 3'd0, 1);
        else     chk_all("stream_tail", 1, 64'd28, 32'h8B1F0407, 3'd1, 1);
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk_all("stream_done", 0, 64'h0, 32'h0, 3'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
